// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer around a bit-serial, MSB-first CRC-8.
// Bytes arrive over valid/ready; the final CRC and byte count leave over valid/ready.
module crc8_frame_ctrl #(
  parameter logic [7:0] POLY   = 8'h8B,
  parameter logic [7:0] INIT   = 8'h00,
  parameter logic [7:0] XOROUT = 8'hFF,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             abort,
  output logic [7:0]       crc_out,
  output logic [CNT_W-1:0] byte_count,
  output logic             crc_valid,
  input  logic             crc_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;

  state_t           state, state_nx;
  logic [7:0]       crc_reg, sh;
  logic [2:0]       bit_cnt;
  logic             last_q, sof;
  logic [CNT_W-1:0] cnt;
  logic             accept, take, fb;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    crc_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SHIFT;
      end
      SHIFT:   if (bit_cnt == 3'd0) state_nx = last_q ? RESULT : IDLE;
      RESULT: begin
        crc_valid = 1'b1;
        if (crc_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // abort wins over everything except reset; a byte offered with it is dropped
    if (abort) state_nx = IDLE;
  end

  assign accept = in_valid & in_ready & ~abort;
  assign take   = crc_valid & crc_ready & ~abort;
  assign fb     = crc_reg[7] ^ sh[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= INIT;
      sh      <= '0;
      bit_cnt <= '0;
      last_q  <= 1'b0;
      cnt     <= '0;
      sof     <= 1'b1;
    end else if (abort) begin
      crc_reg <= INIT;
      cnt     <= '0;
      sof     <= 1'b1;
    end else begin
      if (accept) begin
        sh      <= in_data;
        last_q  <= in_last;
        bit_cnt <= 3'd7;
        sof     <= 1'b0;
        if (sof) crc_reg <= INIT;
        if (!(&cnt)) cnt <= cnt + CNT_W'(1);
      end
      if (state == SHIFT) begin
        crc_reg <= {crc_reg[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        sh      <= {sh[6:0], 1'b0};
        bit_cnt <= bit_cnt - 3'd1;
      end
      if (take) begin
        cnt <= '0;
        sof <= 1'b1;
      end
    end
  end

  assign crc_out    = crc_reg ^ XOROUT;
  assign byte_count = cnt;
  // sof is clear exactly while a frame has started and its result is still pending
  assign busy       = ~sof;
endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Directed, table-driven bench for crc8_frame_ctrl; a 2-bit-count twin shares
// the stimulus to exercise byte_count saturation.
module tb_crc8_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, abort, crc_ready;
  logic [7:0]  in_data;
  logic        in_ready, crc_valid, busy;
  logic [7:0]  crc_out;
  logic [15:0] byte_count;
  logic        s_in_ready, s_crc_valid, s_busy;
  logic [7:0]  s_crc_out;
  logic [1:0]  s_count;

  int nchk = 0, nerr = 0, cyc = 0, last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  crc8_frame_ctrl dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .abort(abort), .crc_out(crc_out), .byte_count(byte_count),
    .crc_valid(crc_valid), .crc_ready(crc_ready), .busy(busy));

  crc8_frame_ctrl #(.CNT_W(2)) sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(s_in_ready), .abort(abort), .crc_out(s_crc_out), .byte_count(s_count),
    .crc_valid(s_crc_valid), .crc_ready(crc_ready), .busy(s_busy));

  typedef struct {
    logic [31:0] data;   // first byte in the top occupied byte lane
    int          n;
    logic [7:0]  crc;
    int          cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the last byte's accept edge.
  task automatic send_frame(input logic [31:0] data, input int n, input string nm);
    int t;
    for (int i = 0; i < n; i++) begin
      in_data  = data[8*(n-1-i) +: 8];
      in_last  = (i == n-1);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (!in_ready) begin
        nchk++; nerr++;
        $display("FAIL %s: in_ready timeout got 0 want 1", nm);
      end
      @(posedge clk);
      if (i > 0) chk({nm, " accept gap"}, cyc - last_acc, 9);
      last_acc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string nm);
    repeat (7) @(negedge clk);
    chk({nm, " valid early"}, {31'b0, crc_valid}, 0);
    @(negedge clk);
    chk({nm, " valid at accept+9"}, {31'b0, crc_valid}, 1);
  endtask

  task automatic take_result(input string nm);
    crc_ready = 1'b1;
    @(negedge clk);
    chk({nm, " valid drop"}, {30'b0, crc_valid, busy}, 0);
    crc_ready = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h00,       1, 8'hFF, 1};
    vecs[1] = '{32'h01,       1, 8'h74, 1};
    vecs[2] = '{32'h80,       1, 8'hAA, 1};
    vecs[3] = '{32'h0100,     2, 8'h55, 2};
    vecs[4] = '{32'h00000000, 4, 8'hFF, 4};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    abort = 1'b0; crc_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset flags", {29'b0, in_ready, crc_valid, busy}, 32'b100);
    chk("reset crc_out", crc_out, 8'hFF);
    chk("reset count", byte_count, 0);

    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].n, $sformatf("vec%0d", v));
      wait_result($sformatf("vec%0d", v));
      chk($sformatf("vec%0d crc", v), crc_out, vecs[v].crc);
      chk($sformatf("vec%0d count", v), byte_count, vecs[v].cnt);
      chk($sformatf("vec%0d sat count", v), s_count, (vecs[v].cnt > 3) ? 3 : vecs[v].cnt);
      chk($sformatf("vec%0d busy/ready", v), {30'b0, busy, in_ready}, 32'b10);
      take_result($sformatf("vec%0d", v));
    end

    // Backpressure: result held, new byte refused
    send_frame(32'h80, 1, "bp");
    wait_result("bp");
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp hold %0d", k), {14'b0, crc_valid, in_ready, byte_count}, {14'b0, 2'b10, 16'd1});
      chk($sformatf("bp crc %0d", k), crc_out, 8'hAA);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take_result("bp");
    send_frame(32'h01, 1, "reinit");
    wait_result("reinit");
    chk("reinit crc", crc_out, 8'h74);
    take_result("reinit");

    // Abort on the 4th SHIFT cycle of frame 0x80
    send_frame(32'h80, 1, "abort");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort idle", {29'b0, in_ready, busy, crc_valid}, 32'b100);
    repeat (10) @(negedge clk);
    chk("abort no result", {31'b0, crc_valid}, 0);

    // Byte offered together with abort in IDLE is dropped
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; abort = 1'b0;
    chk("abort drop", {30'b0, in_ready, busy}, 32'b10);
    send_frame(32'h00, 1, "post abort");
    wait_result("post abort");
    chk("post abort crc", crc_out, 8'hFF);
    chk("post abort count", byte_count, 1);

    // Reset while holding a result
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst in result", {13'b0, in_ready, crc_valid, busy, byte_count}, {13'b0, 3'b100, 16'd0});
    chk("rst crc_out", crc_out, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
